m_dm: RTL and testbench

- Data memory of the M stage in the 5-stage pipelined MIPS CPU.
- Directly downstream of the E-stage ALU: the ALU result (carried through the E/M register) is the byte address here.
- Performs word/half/byte stores as read-modify-write of a 32-bit word array.
- Returns zero- or sign-extended load data combinationally to the M/W register.

---
 rtl/m_dm.sv | 97 +++++++++
 tb/tb_m_dm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/m_dm.sv
// M-stage data memory: word/half/byte loads and read-modify-write stores on a 32-bit word array.
// Optional store trace printing enabled by defining DM_TRACE_EN.
module m_dm #(
   parameter int WORDS = 4096,
   parameter int AW    = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC,
   input  logic        MemWrite,
   input  logic [2:0]  DMOp,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        AdErr
);

   localparam logic [32:0] LIMIT = 33'(4 * WORDS);

   logic [31:0]   r_mem [WORDS];
   logic [AW-1:0] w_idx;
   logic [31:0]   w_word;
   logic [31:0]   w_merged;
   logic [15:0]   w_half;
   logic [7:0]    w_byte;

   function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
      return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
   endfunction

   function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
      return sgn ? {{24{b[7]}}, b} : {24'h000000, b};
   endfunction

   assign w_idx  = Addr[AW+1:2];
   assign w_word = r_mem[w_idx];
   assign w_half = Addr[1] ? w_word[31:16] : w_word[15:0];
   assign w_byte = w_word[{Addr[1:0], 3'b000} +: 8];

   // Alignment/range check applies to loads and stores alike
   always_comb begin
      AdErr = 1'b0;
      if ({1'b0, Addr} >= LIMIT) AdErr = 1'b1;
      case (DMOp)
         3'd0:       if (Addr[1:0] != 2'b00) AdErr = 1'b1;
         3'd1, 3'd2: if (Addr[0]) AdErr = 1'b1;
         3'd3, 3'd4: ;
         default:    AdErr = 1'b1;
      endcase
   end

   always_comb begin
      RD = 32'h0;
      if (!AdErr) begin
         case (DMOp)
            3'd0:    RD = w_word;
            3'd1:    RD = ext16(w_half, 1'b1);
            3'd2:    RD = ext16(w_half, 1'b0);
            3'd3:    RD = ext8(w_byte, 1'b1);
            3'd4:    RD = ext8(w_byte, 1'b0);
            default: RD = 32'h0;
         endcase
      end
   end

   // Store data merged onto the current word contents
   always_comb begin
      w_merged = w_word;
      case (DMOp)
         3'd0:       w_merged = WD;
         3'd1, 3'd2: begin
            if (Addr[1]) w_merged[31:16] = WD[15:0];
            else         w_merged[15:0]  = WD[15:0];
         end
         3'd3, 3'd4: w_merged[{Addr[1:0], 3'b000} +: 8] = WD[7:0];
         default:    w_merged = w_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) r_mem[i] <= 32'h0;
      end else if (MemWrite && !AdErr) begin
         r_mem[w_idx] <= w_merged;
`ifdef DM_TRACE_EN
         $display("@%08h: *%08h <= %08h", PC, {Addr[31:2], 2'b00}, w_merged);
`endif
      end
   end

`ifdef DM_TRACE_EN
`else
   logic w_unused_pc;
   assign w_unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_m_dm.sv
// Self-checking bench for m_dm: directed vector table, multi-cycle corner sequences and
// randomized traffic compared against a byte-addressed reference memory.
module tb_m_dm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC;
   logic        MemWrite;
   logic [2:0]  DMOp;
   logic [31:0] Addr;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        AdErr;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int NBYTES = 16384;
   logic [7:0] mb [NBYTES];

   m_dm dut (
      .clk(clk), .reset(reset), .PC(PC), .MemWrite(MemWrite), .DMOp(DMOp),
      .Addr(Addr), .WD(WD), .RD(RD), .AdErr(AdErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic m_err(input logic [2:0] op, input logic [31:0] a);
      if (a >= NBYTES) return 1'b1;
      if (op > 3'd4) return 1'b1;
      if (op == 3'd0 && (a % 4) != 0) return 1'b1;
      if ((op == 3'd1 || op == 3'd2) && (a % 2) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] op, input logic [31:0] a);
      int v;
      if (m_err(op, a)) return 32'h0;
      case (op)
         3'd0: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
         3'd1: begin v = $signed({mb[a+1], mb[a]}); return 32'(v); end
         3'd2: return {16'h0, mb[a+1], mb[a]};
         3'd3: begin v = $signed(mb[a]); return 32'(v); end
         default: return {24'h0, mb[a]};
      endcase
   endfunction

   task automatic m_write(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      if (m_err(op, a)) return;
      case (op)
         3'd0: begin mb[a] = d[7:0]; mb[a+1] = d[15:8]; mb[a+2] = d[23:16]; mb[a+3] = d[31:24]; end
         3'd1, 3'd2: begin mb[a] = d[7:0]; mb[a+1] = d[15:8]; end
         default: mb[a] = d[7:0];
      endcase
   endtask

   task automatic m_clear();
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
   endtask

   // One bus cycle: drive after the edge, sample at negedge, model the following edge
   task automatic cyc(input logic rst, input logic we, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err);
      @(posedge clk); #1;
      reset = rst; MemWrite = we; DMOp = op; Addr = a; WD = d; PC = PC + 4;
      @(negedge clk);
      rd = RD; err = AdErr;
      if (rst) m_clear();
      else if (we) m_write(op, a, d);
   endtask

   task automatic load_chk(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] exp);
      logic [31:0] rd; logic err;
      cyc(1'b0, 1'b0, op, a, 32'h0, rd, err);
      chk(name, rd, exp);
   endtask

   initial begin
      logic [31:0] rd, d, a;
      logic err;
      logic [2:0] op;
      logic we;

      PC = 32'h0040_0000; reset = 1'b1; MemWrite = 1'b0; DMOp = 3'd0; Addr = 32'h0; WD = 32'h0;
      m_clear();
      repeat (2) @(posedge clk);
      load_chk("reset_rd0", 3'd0, 32'h0, 32'h0);
      chk("reset_aderr", {31'h0, AdErr}, 32'h0);

      // Dirty a few words, then a single reset edge must clear them
      cyc(1'b0, 1'b1, 3'd0, 32'h0,    32'h1234_5678, rd, err);
      cyc(1'b0, 1'b1, 3'd0, 32'h4,    32'hA5A5_5A5A, rd, err);
      cyc(1'b0, 1'b1, 3'd0, 32'h3FFC, 32'hFFFF_FFFF, rd, err);
      load_chk("pre_reset_3ffc", 3'd0, 32'h3FFC, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, rd, err);
      load_chk("post_reset_0",    3'd0, 32'h0,    32'h0);
      load_chk("post_reset_4",    3'd0, 32'h4,    32'h0);
      load_chk("post_reset_3ffc", 3'd0, 32'h3FFC, 32'h0);

      tbl.push_back('{"sw_10",     1, 3'd0, 32'h10,   32'h8899AABB, 32'h00000000, 0});
      tbl.push_back('{"lw_10",     0, 3'd0, 32'h10,   32'h0,        32'h8899AABB, 0});
      tbl.push_back('{"lb_13",     0, 3'd3, 32'h13,   32'h0,        32'hFFFFFF88, 0});
      tbl.push_back('{"lbu_13",    0, 3'd4, 32'h13,   32'h0,        32'h00000088, 0});
      tbl.push_back('{"lh_10",     0, 3'd1, 32'h10,   32'h0,        32'hFFFFAABB, 0});
      tbl.push_back('{"lhu_12",    0, 3'd2, 32'h12,   32'h0,        32'h00008899, 0});
      tbl.push_back('{"sb_11",     1, 3'd3, 32'h11,   32'h12345677, 32'hFFFFFFAA, 0});
      tbl.push_back('{"lw_sb",     0, 3'd0, 32'h10,   32'h0,        32'h889977BB, 0});
      tbl.push_back('{"sh_12",     1, 3'd1, 32'h12,   32'h0000CAFE, 32'hFFFF8899, 0});
      tbl.push_back('{"lw_sh",     0, 3'd0, 32'h10,   32'h0,        32'hCAFE77BB, 0});
      tbl.push_back('{"sw_22_err", 1, 3'd0, 32'h22,   32'hDEADBEEF, 32'h00000000, 1});
      tbl.push_back('{"lw_20",     0, 3'd0, 32'h20,   32'h0,        32'h00000000, 0});
      tbl.push_back('{"lh_21_err", 0, 3'd1, 32'h21,   32'h0,        32'h00000000, 1});
      tbl.push_back('{"sw_oor",    1, 3'd0, 32'h4000, 32'hDEADBEEF, 32'h00000000, 1});
      tbl.push_back('{"lw_0_oor",  0, 3'd0, 32'h0,    32'h0,        32'h00000000, 0});
      tbl.push_back('{"op6_err",   0, 3'd6, 32'h10,   32'h0,        32'h00000000, 1});
      tbl.push_back('{"sb_30",     1, 3'd3, 32'h30,   32'h00000011, 32'h00000000, 0});
      tbl.push_back('{"sb_31",     1, 3'd3, 32'h31,   32'h00000022, 32'h00000000, 0});
      tbl.push_back('{"sb_32",     1, 3'd3, 32'h32,   32'h00000033, 32'h00000000, 0});
      tbl.push_back('{"sb_33",     1, 3'd3, 32'h33,   32'h00000044, 32'h00000000, 0});
      tbl.push_back('{"lw_30",     0, 3'd0, 32'h30,   32'h0,        32'h44332211, 0});

      foreach (tbl[i]) begin
         cyc(1'b0, tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd, rd, err);
         chk({tbl[i].name, "_rd"}, rd, tbl[i].rd);
         chk({tbl[i].name, "_err"}, {31'h0, err}, {31'h0, tbl[i].err});
      end

      // Reset takes priority over a store on the same edge
      cyc(1'b0, 1'b1, 3'd0, 32'h8, 32'h0000_0001, rd, err);
      load_chk("pre_rst_store_8", 3'd0, 32'h8, 32'h0000_0001);
      cyc(1'b1, 1'b1, 3'd0, 32'h8, 32'hDEADBEEF, rd, err);
      load_chk("rst_beats_store", 3'd0, 32'h8, 32'h0);
      load_chk("rst_clears_10",   3'd0, 32'h10, 32'h0);

      // Randomized traffic confined mostly to a small window so loads hit stored data
      for (int n = 0; n < 3000; n++) begin
         we = ($urandom_range(0, 1) == 1);
         op = 3'($urandom_range(0, 9) > 8 ? $urandom_range(5, 7) : $urandom_range(0, 4));
         case ($urandom_range(0, 9))
            0:       a = 32'h3F00 + $urandom_range(0, 255);
            1:       a = 32'h4000 + $urandom_range(0, 255);
            2:       a = $urandom;
            default: a = $urandom_range(0, 127);
         endcase
         d = $urandom;
         begin
            logic [31:0] exp_rd;
            logic        exp_err;
            exp_rd  = m_read(op, a);
            exp_err = m_err(op, a);
            cyc(1'b0, we, op, a, d, rd, err);
            chk("rand_rd", rd, exp_rd);
            chk("rand_err", {31'h0, err}, {31'h0, exp_err});
         end
      end

      // Final sweep of the window against the model
      for (int w = 0; w < 32; w++) begin
         a = 32'(w * 4);
         load_chk("sweep_lw", 3'd0, a, {mb[a+3], mb[a+2], mb[a+1], mb[a]});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
